pc_target_unit: RTL and testbench
=================================

Name: pc_target_unit

Overview:
- Program counter plus programmable branch-target table; successor to the fixed combinational target LUT.
- Each table entry holds a D-bit target and a mode bit: relative (signed offset, mod 2^D) or absolute.
- The table is cleared by a post-reset init sweep and loaded at run time through a write port.
- Sits in the fetch stage: drives prog_ctr to instruction ROM; control supplies branch/index/stall/done.

Parameters:
D, 12, PC and target width in bits
A, 3, table index width; DEPTH = 2**A entries

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high
wr_en  in  1  write table entry (honoured only in RUN)
wr_addr  in  A  entry to write
wr_target  in  D  target value / two's-complement offset
wr_abs  in  1  1 = absolute target, 0 = relative offset
branch  in  1  take branch this cycle
jump_idx  in  A  table entry used when branch=1
stall  in  1  level; hold PC
done_req  in  1  pulse; enter sticky DONE
rd_addr  in  A  debug readback index
rd_target  out  D  combinational readback of entry rd_addr target
rd_abs  out  1  combinational readback of entry rd_addr mode
prog_ctr  out  D  current PC (registered)
init_done  out  1  1 when table clear complete (RUN or DONE)
done  out  1  1 in DONE state

Behaviour:
- States: INIT, RUN, DONE.
- Reset (any state, any cycle, including mid-sweep):
  - next state INIT, prog_ctr=0, init_cnt=0, init_done=0, done=0.
  - Table contents are not reset directly; they are cleared by the sweep.
- INIT:
  - Each cycle writes entry init_cnt := {target=0, abs=0}, i.e. relative 0 = "hold PC"; init_cnt increments.
  - After writing entry DEPTH-1, go to RUN; INIT lasts exactly DEPTH cycles after Reset deasserts.
  - prog_ctr held 0. wr_en, branch, stall and done_req are ignored.
  - init_done=1 from the first RUN cycle.
- RUN, PC update priority:
  - done_req: hold PC, go to DONE.
  - else stall: hold PC.
  - else branch with abs=1: PC := target.
  - else branch with abs=0: PC := (PC + target) mod 2^D; e.g. 0xFFF = -1, 0xFFB = -5.
  - else PC := PC+1, wrapping 0xFFF -> 0x000.
- Branch latency: new PC is visible the cycle after branch is sampled.
- Writes (RUN only):
  - Entry updates at the clock edge; visible to branch and readback from the next cycle.
  - Same-cycle branch on the written index uses the old contents.
  - Writes are still accepted while stall=1.
- DONE:
  - Sticky until Reset; PC frozen, done=1. Branch, stall, done_req ignored.
  - Writes still accepted, so the table stays debuggable.
- Readback is combinational from storage in every state; during INIT it may show partially cleared contents.
- Arithmetic: all adds are D-bit, carry discarded; no overflow flag.

Decomposition:
- Package pc_pkg:
  - typedef enum {INIT, RUN, DONE} pc_state_t.
  - struct pc_entry_t {logic abs; logic [D-1:0] target}, parametrised via package localparam defaults matching D=12.
  - localparam PC_RESET = 0.
- Sub-module pc_target_table:
  - DEPTH x pc_entry_t storage, one write port (muxed between init sweep and wr_*), two combinational read ports (jump_idx, rd_addr).
- Top level: FSM, init counter, PC register, next-PC mux/adder.

Test Plan:
- Reset for 2 cycles, release -> prog_ctr=0 and init_done=0 for 8 cycles (A=3), then init_done=1; PC counts 0,1,2,... and readback of every entry = {0,0}.
- Write entry 1 = {abs=0, 0xFFC}; at PC=0x010 assert branch idx=1 -> next PC 0x00C. Write entry 4 = {abs=1, 0x064}; branch idx=4 -> next PC 0x064.
- Run with PC=0xFFF, no branch -> PC=0x000. Entry rel +0x014 from PC=0xFF0 -> PC=0x004.
- Same cycle write entry 2 = {abs=1, 0x200} and branch idx=2 (cleared, rel 0) -> PC holds; branch idx=2 next cycle -> PC=0x200.
- stall=1 together with branch=1 for 3 cycles -> PC unchanged. done_req together with branch -> PC frozen, done=1, stays after stall/branch toggling.
- Assert Reset at sweep cycle 3 after writing entries in RUN -> sweep restarts, full 8 cycles; all entries read {0,0} afterwards.

Source files
------------

// File: rtl/pc_target_unit_pkg.sv
// Shared types and widths for the fetch-stage program counter and its
// programmable branch-target table.
package pc_pkg;

    localparam int PC_W  = 12;
    localparam int IDX_W = 3;

    localparam logic [PC_W-1:0] PC_RESET = '0;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        DONE
    } pc_state_t;

    typedef struct packed {
        logic            abs;
        logic [PC_W-1:0] target;
    } pc_entry_t;

    // Relative targets are two's-complement offsets; the add wraps at PC_W bits.
    function automatic logic [PC_W-1:0] resolve_target(pc_entry_t entry, logic [PC_W-1:0] pc);
        return entry.abs ? entry.target : pc + entry.target;
    endfunction

endpackage

// File: rtl/pc_target_unit_if.sv
// Control-side bundle of the PC/target unit: table write port, branch
// controls, debug readback and PC/status outputs.
interface pc_target_unit_if #(
    parameter int D = pc_pkg::PC_W,
    parameter int A = pc_pkg::IDX_W
);

    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_target;
    logic         wr_abs;
    logic         branch;
    logic [A-1:0] jump_idx;
    logic         stall;
    logic         done_req;
    logic [A-1:0] rd_addr;
    logic [D-1:0] rd_target;
    logic         rd_abs;
    logic [D-1:0] prog_ctr;
    logic         init_done;
    logic         done;

    modport master (
        output wr_en, wr_addr, wr_target, wr_abs, branch, jump_idx,
               stall, done_req, rd_addr,
        input  rd_target, rd_abs, prog_ctr, init_done, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_target, wr_abs, branch, jump_idx,
               stall, done_req, rd_addr,
        output rd_target, rd_abs, prog_ctr, init_done, done
    );

endinterface

// File: rtl/pc_target_unit_table.sv
// Branch-target storage: one synchronous write port, two combinational
// read ports (branch lookup and debug readback).
module pc_target_table
    import pc_pkg::*;
#(
    parameter int A = IDX_W
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  pc_entry_t    wdata,
    input  logic [A-1:0] jump_addr,
    output pc_entry_t    jump_entry,
    input  logic [A-1:0] rd_addr,
    output pc_entry_t    rd_entry
);

    localparam int DEPTH = 2 ** A;

    pc_entry_t mem [DEPTH];

    // NOTE: storage has no reset term; the owner clears it with a write sweep,
    // which keeps this a plain RAM-style array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign jump_entry = mem[jump_addr];
    assign rd_entry   = mem[rd_addr];

endmodule

// File: rtl/pc_target_unit.sv
// Program counter with a programmable branch-target table, cleared by a
// post-reset sweep before fetch starts.
module pc_target_unit
    import pc_pkg::*;
#(
    parameter int D = PC_W,
    parameter int A = IDX_W
) (
    input  logic             Clk,
    input  logic             Reset,
    pc_target_unit_if.slave  bus
);

    localparam int DEPTH = 2 ** A;

    pc_state_t    state;
    logic [A-1:0] init_cnt;
    logic [D-1:0] pc_q;
    logic         init_done_q;
    logic         done_q;

    logic         tbl_we;
    logic [A-1:0] tbl_waddr;
    pc_entry_t    tbl_wdata;
    pc_entry_t    jump_entry;
    pc_entry_t    rd_entry;
    logic [D-1:0] next_pc;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = bus.wr_addr;
        tbl_wdata = pc_entry_t'{abs: bus.wr_abs, target: bus.wr_target};
        if (!Reset) begin
            unique case (state)
                INIT: begin
                    tbl_we    = 1'b1;
                    tbl_waddr = init_cnt;
                    tbl_wdata = '0;
                end
                RUN, DONE: tbl_we = bus.wr_en;
                default: tbl_we = 1'b0;
            endcase
        end
    end

    pc_target_table #(.A(A)) u_table (
        .clk       (Clk),
        .we        (tbl_we),
        .waddr     (tbl_waddr),
        .wdata     (tbl_wdata),
        .jump_addr (bus.jump_idx),
        .jump_entry(jump_entry),
        .rd_addr   (bus.rd_addr),
        .rd_entry  (rd_entry)
    );

    // Branch lookup sees pre-write contents, so a same-cycle write never bypasses.
    always_comb begin
        next_pc = pc_q + D'(1);
        if (bus.branch) begin
            next_pc = resolve_target(jump_entry, pc_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= INIT;
            init_cnt    <= '0;
            pc_q        <= PC_RESET;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + A'(1);
                    if (init_cnt == A'(DEPTH - 1)) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.done_req) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= next_pc;
                    end
                end
                DONE: ;
                default: state <= INIT;
            endcase
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.init_done = init_done_q;
    assign bus.done      = done_q;
    assign bus.rd_target = rd_entry.target;
    assign bus.rd_abs    = rd_entry.abs;

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed plus randomized bench for pc_target_unit, checked against a
// behavioural table/PC model kept in the bench.
module tb_pc_target_unit;

    localparam int D     = 12;
    localparam int A     = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_target_unit_if #(.D(D), .A(A)) bus ();

    pc_target_unit #(.D(D), .A(A)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: PC, table contents, sweep progress, done flag.
    logic [D-1:0] m_pc;
    logic [D-1:0] m_tgt   [DEPTH];
    logic         m_abs   [DEPTH];
    bit           m_valid [DEPTH];
    int           m_sweep;
    bit           m_done;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        int idx;
        int j;
        if (rst) begin
            m_sweep = DEPTH;
            m_pc    = '0;
            m_done  = 1'b0;
        end else if (m_sweep > 0) begin
            idx          = DEPTH - m_sweep;
            m_tgt[idx]   = '0;
            m_abs[idx]   = 1'b0;
            m_valid[idx] = 1'b1;
            m_sweep--;
        end else begin
            if (!m_done) begin
                j = int'(bus.jump_idx);
                if (bus.done_req)    m_done = 1'b1;
                else if (bus.stall)  m_pc = m_pc;
                else if (!bus.branch) m_pc = m_pc + 12'd1;
                else if (m_abs[j])   m_pc = m_tgt[j];
                else                 m_pc = m_pc + m_tgt[j];
            end
            if (bus.wr_en) begin
                idx          = int'(bus.wr_addr);
                m_tgt[idx]   = bus.wr_target;
                m_abs[idx]   = bus.wr_abs;
                m_valid[idx] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int r;
        chk("prog_ctr", 32'(bus.prog_ctr), 32'(m_pc));
        chk("init_done", 32'(bus.init_done), (m_sweep == 0) ? 32'd1 : 32'd0);
        chk("done", 32'(bus.done), 32'(m_done));
        r = int'(bus.rd_addr);
        if (m_valid[r]) begin
            chk("rd_target", 32'(bus.rd_target), 32'(m_tgt[r]));
            chk("rd_abs", 32'(bus.rd_abs), 32'(m_abs[r]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit we, input int wa, input int wt, input bit wabs,
                         input bit br, input int ji, input bit st, input bit dr);
        bus.wr_en     = we;
        bus.wr_addr   = A'(wa);
        bus.wr_target = D'(wt);
        bus.wr_abs    = wabs;
        bus.branch    = br;
        bus.jump_idx  = A'(ji);
        bus.stall     = st;
        bus.done_req  = dr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_rd(input int idx, input int exp_t, input bit exp_a);
        bus.rd_addr = A'(idx);
        #1;
        chk("readback_target", 32'(bus.rd_target), 32'(exp_t));
        chk("readback_abs", 32'(bus.rd_abs), 32'(exp_a));
    endtask

    task automatic run_to(input logic [D-1:0] target);
        int budget = 5000;
        idle();
        while (m_pc != target && budget > 0) begin
            cycle();
            budget--;
        end
        if (m_pc != target) chk("run_to_budget", 32'(m_pc), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [D-1:0] hold;
        idle();
        bus.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;

        // Reset and init sweep
        #1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle();
            chk("init_done_low", 32'(bus.init_done), 32'd0);
            chk("init_pc_zero", 32'(bus.prog_ctr), 32'd0);
        end
        cycle();
        chk("init_done_high", 32'(bus.init_done), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("count_up", 32'(bus.prog_ctr), 32'(i));
        end
        for (int i = 0; i < DEPTH; i++) check_rd(i, 0, 1'b0);

        // Relative and absolute branches
        drive(1, 1, 'hFFC, 0, 0, 0, 0, 0);
        cycle();
        run_to(12'h010);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        chk("branch_rel_neg4", 32'(bus.prog_ctr), 32'h00C);
        drive(1, 4, 'h064, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        cycle();
        chk("branch_abs_064", 32'(bus.prog_ctr), 32'h064);

        // Wraparound on increment and on relative add
        drive(1, 5, 'hFFF, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        cycle();
        chk("branch_abs_fff", 32'(bus.prog_ctr), 32'hFFF);
        idle();
        cycle();
        chk("inc_wrap", 32'(bus.prog_ctr), 32'h000);
        drive(1, 6, 'hFF0, 1, 0, 0, 0, 0);
        cycle();
        drive(1, 7, 'h014, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 6, 0, 0);
        cycle();
        chk("branch_abs_ff0", 32'(bus.prog_ctr), 32'hFF0);
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        cycle();
        chk("rel_add_wrap", 32'(bus.prog_ctr), 32'h004);

        // Same-cycle write and branch uses old (cleared, rel 0) contents
        drive(1, 2, 'h200, 1, 1, 2, 0, 0);
        cycle();
        chk("same_cycle_old", 32'(bus.prog_ctr), 32'h004);
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        cycle();
        chk("next_cycle_new", 32'(bus.prog_ctr), 32'h200);

        // Stall overrides branch; writes still land
        drive(1, 3, 'h123, 1, 1, 4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold", 32'(bus.prog_ctr), 32'h200);
        end
        idle();
        check_rd(3, 'h123, 1'b1);

        // Randomized run phase
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
                  int'($urandom_range(0, 4095)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 4) == 0, 0);
            bus.rd_addr = A'($urandom_range(0, DEPTH - 1));
            cycle();
        end

        // done_req wins over branch; DONE is sticky, writes still accepted
        hold = m_pc;
        drive(0, 0, 0, 0, 1, 4, 0, 1);
        cycle();
        chk("done_set", 32'(bus.done), 32'd1);
        chk("done_pc_frozen", 32'(bus.prog_ctr), 32'(hold));
        for (int i = 0; i < 20; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                  int'($urandom_range(0, 4095)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            bus.rd_addr = A'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        chk("done_sticky", 32'(bus.done), 32'd1);
        chk("done_pc_still", 32'(bus.prog_ctr), 32'(hold));

        // Reset mid-sweep restarts the full sweep
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rd_addr = A'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        rst = 1'b1;
        cycle();
        chk("reset_clears_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle();
            chk("resweep_low", 32'(bus.init_done), 32'd0);
        end
        cycle();
        chk("resweep_high", 32'(bus.init_done), 32'd1);
        chk("resweep_pc", 32'(bus.prog_ctr), 32'd0);
        for (int i = 0; i < DEPTH; i++) check_rd(i, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
